// File: rtl/bch63_56_encoder.sv
// Systematic BCH(63,56) encoder: latches a 56-bit message, streams the 63-bit
// codeword MSB first with a bit-serial LFSR for parity, and reports it in parallel.
module bch63_56_encoder #(
  parameter int                 MSG_W   = 56,
  parameter int                 PAR_W   = 7,
  parameter logic [PAR_W-1:0]   GEN_LOW = 7'h45
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MSG_W-1:0]         msg_in,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  input  logic                     out_ready,
  output logic                     code_bit,
  output logic                     code_valid,
  output logic                     code_first,
  output logic                     code_last,
  output logic [MSG_W+PAR_W-1:0]   cw_out,
  output logic                     cw_done
);

  localparam int          CW_W         = MSG_W + PAR_W;
  localparam logic [5:0]  CNT_MSG_LAST = 6'(MSG_W - 1);
  localparam logic [5:0]  CNT_PAR_LAST = 6'(PAR_W - 1);

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  state_t              state_reg, state_next;
  logic [MSG_W-1:0]    msg_reg;
  logic [PAR_W-1:0]    r_reg;
  logic [5:0]          cnt_reg;
  logic [CW_W-2:0]     cw_acc_reg;
  logic [CW_W-1:0]     cw_out_reg;
  logic                cw_done_reg;
  logic                xfer;
  logic                fb;

  always_comb begin
    state_next = state_reg;
    msg_ready  = 1'b0;
    code_valid = 1'b0;
    code_bit   = 1'b0;
    code_first = 1'b0;
    code_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_next = MSG;
      end
      MSG: begin
        code_valid = 1'b1;
        code_bit   = msg_reg[MSG_W-1];
        code_first = (cnt_reg == 6'd0);
        if (out_ready && cnt_reg == CNT_MSG_LAST) state_next = PAR;
      end
      PAR: begin
        code_valid = 1'b1;
        code_bit   = r_reg[PAR_W-1];
        code_last  = (cnt_reg == CNT_PAR_LAST);
        if (out_ready && cnt_reg == CNT_PAR_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign xfer = code_valid & out_ready;
  assign fb   = code_bit ^ r_reg[PAR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      msg_reg     <= '0;
      r_reg       <= '0;
      cnt_reg     <= '0;
      cw_acc_reg  <= '0;
      cw_out_reg  <= '0;
      cw_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cw_done_reg <= 1'b0;
      if (msg_valid && msg_ready) begin
        msg_reg <= msg_in;
        r_reg   <= '0;
        cnt_reg <= '0;
      end else if (xfer) begin
        // Every transmitted bit is also collected so the parallel codeword
        // is simply the serial stream, independent of the message register.
        cw_acc_reg <= {cw_acc_reg[CW_W-3:0], code_bit};
        if (state_reg == MSG) begin
          msg_reg <= msg_reg << 1;
          r_reg   <= {r_reg[PAR_W-2:0], 1'b0} ^ (fb ? GEN_LOW : '0);
          cnt_reg <= (cnt_reg == CNT_MSG_LAST) ? 6'd0 : cnt_reg + 6'd1;
        end else begin
          r_reg   <= {r_reg[PAR_W-2:0], 1'b0};
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == CNT_PAR_LAST) begin
            cw_out_reg  <= {cw_acc_reg, code_bit};
            cw_done_reg <= 1'b1;
            cnt_reg     <= 6'd0;
          end
        end
      end
    end
  end

  assign cw_out  = cw_out_reg;
  assign cw_done = cw_done_reg;

endmodule

// File: tb/tb_bch63_56_encoder.sv
// Bench for bch63_56_encoder: polynomial-division reference model, per-cycle
// stream/handshake checks, directed literal codewords, stalls, held-valid and reset.
module tb_bch63_56_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] msg_in = '0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic        out_ready = 1'b1;
  logic        code_bit, code_valid, code_first, code_last;
  logic [62:0] cw_out;
  logic        cw_done;

  int total = 0;
  int bad   = 0;
  int stall_pct = 0;
  int cyc = 0;
  int bits_sent = 0;
  int frames = 0;

  bit          q[$];
  int          accept_cyc[$];
  logic [62:0] frame_cw, exp_cw;
  bit          exp_done = 0;
  bit          hold_valid = 0;
  bit          hold_bit = 0;
  int          idx;

  bch63_56_encoder dut (
    .clk(clk), .rst_n(rst_n), .msg_in(msg_in), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .out_ready(out_ready), .code_bit(code_bit),
    .code_valid(code_valid), .code_first(code_first), .code_last(code_last),
    .cw_out(cw_out), .cw_done(cw_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Remainder of a degree<63 polynomial divided by g(x) = x^7+x^6+x^2+1.
  function automatic logic [6:0] rem63(input logic [62:0] v);
    logic [62:0] t = v;
    for (int i = 62; i >= 7; i--)
      if (t[i]) t[i -: 8] = t[i -: 8] ^ 8'hC5;
    return t[6:0];
  endfunction

  function automatic logic [62:0] encode(input logic [55:0] m);
    return {m, rem63({m, 7'b0})};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2 out_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_code_valid", 64'(code_valid), 64'd0);
      chk("rst_cw_done", 64'(cw_done), 64'd0);
      chk("rst_msg_ready", 64'(msg_ready), 64'd1);
      q.delete();
      exp_done   = 0;
      hold_valid = 0;
    end else begin
      chk("cw_done", 64'(cw_done), 64'(exp_done));
      if (exp_done) begin
        int pos, found;
        logic [6:0] syn;
        frames++;
        $display("frame %0d cw_out=%h", frames, cw_out);
        chk("cw_out", 64'(cw_out), 64'(exp_cw));
        chk("even_weight", 64'($countones(cw_out) % 2), 64'd0);
        chk("syndrome_zero", 64'(rem63(cw_out)), 64'd0);
        pos = $urandom_range(62);
        syn = rem63(cw_out ^ (63'd1 << pos));
        found = -1;
        for (int p = 0; p < 63; p++)
          if (rem63(63'd1 << p) == syn) found = p;
        chk("flip_pos", 64'(found), 64'(pos));
        exp_done = 0;
      end
      chk("msg_ready", 64'(msg_ready), 64'(q.size() == 0));
      chk("code_valid", 64'(code_valid), 64'(q.size() != 0));
      if (code_valid && q.size() != 0) begin
        idx = 63 - q.size();
        chk("code_bit", 64'(code_bit), 64'(q[0]));
        chk("code_first", 64'(code_first), 64'(idx == 0));
        chk("code_last", 64'(code_last), 64'(idx == 62));
        if (hold_valid) chk("stall_hold", 64'(code_bit), 64'(hold_bit));
        if (out_ready) begin
          void'(q.pop_front());
          bits_sent++;
          hold_valid = 0;
          if (idx == 62) begin
            exp_done = 1;
            exp_cw   = frame_cw;
          end
        end else begin
          hold_valid = 1;
          hold_bit   = code_bit;
        end
      end
      if (msg_valid && msg_ready) begin
        frame_cw = encode(msg_in);
        for (int i = 62; i >= 0; i--) q.push_back(frame_cw[i]);
        accept_cyc.push_back(cyc);
        bits_sent = 0;
      end
    end
  end

  // Called in the posedge+2 phase; returns in the same phase after the accept edge.
  task automatic send_msg(input logic [55:0] m);
    bit got = 0;
    int n = 0;
    msg_in    = m;
    msg_valid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = msg_ready;
      @(posedge clk);
      #2;
      n++;
    end
    msg_valid = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    int n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      #1 seen = cw_done;
      n++;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [55:0] m;
    int n0, n;
    #1;
    chk("init_msg_ready", 64'(msg_ready), 64'd1);
    chk("init_code_valid", 64'(code_valid), 64'd0);
    chk("init_code_bit", 64'(code_bit), 64'd0);
    chk("init_first_last", 64'({code_first, code_last}), 64'd0);
    chk("init_cw_out", 64'(cw_out), 64'd0);
    chk("init_cw_done", 64'(cw_done), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    stall_pct = 0;
    send_msg(56'h0);
    wait_done();
    chk("lit_zero", 64'(cw_out), 64'd0);
    send_msg(56'h1);
    wait_done();
    chk("lit_one", 64'(cw_out), 64'({55'b0, 1'b1, 7'b1000101}));
    send_msg(56'h2);
    wait_done();
    chk("lit_two", 64'(cw_out), 64'({54'b0, 2'b10, 7'b1001111}));

    stall_pct = 30;
    for (int k = 0; k < 200; k++) begin
      m = {$urandom, $urandom};
      send_msg(m);
      wait_done();
      chk("rand_cw", 64'(cw_out), 64'(encode(m)));
    end

    // msg_valid held high with msg_in churning every cycle.
    stall_pct = 0;
    repeat (4) @(posedge clk);
    #2;
    n0 = accept_cyc.size();
    msg_valid = 1'b1;
    repeat (261) begin
      @(posedge clk);
      #2 msg_in = {$urandom, $urandom};
    end
    msg_valid = 1'b0;
    wait_done();
    n = accept_cyc.size() - n0;
    chk("held_accepts", 64'(n), 64'd5);
    for (int k = n0 + 1; k < accept_cyc.size(); k++)
      chk("accept_period", 64'(accept_cyc[k] - accept_cyc[k-1]), 64'd64);

    // Reset in the middle of a frame.
    m = {$urandom, $urandom};
    send_msg(m);
    n = 0;
    while (bits_sent < 30 && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    if (bits_sent < 30) chk("bit30_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_code_valid", 64'(code_valid), 64'd0);
    chk("mid_rst_code_bit", 64'(code_bit), 64'd0);
    chk("mid_rst_first_last", 64'({code_first, code_last}), 64'd0);
    chk("mid_rst_cw_done", 64'(cw_done), 64'd0);
    chk("mid_rst_cw_out", 64'(cw_out), 64'd0);
    chk("mid_rst_msg_ready", 64'(msg_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_msg_ready", 64'(msg_ready), 64'd1);
    chk("post_rst_cw_done", 64'(cw_done), 64'd0);
    #1;
    m = {$urandom, $urandom};
    send_msg(m);
    wait_done();
    chk("post_rst_cw", 64'(cw_out), 64'(encode(m)));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
